reg_file_bank: RTL

- Parametrised register bank with one write port, one combinational ALU read port and one registered dump read port.
- Adds a sequential clear engine with a busy/done handshake.
- Sits between the datapath MUX/ACC and the ALU.
- Replaces the fixed 16x8 register file. There is no tristate output; all outputs are always driven.

---
 rtl/reg_file_bank.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/reg_file_bank.sv
// Parametrised register bank: write port, combinational ALU read port (A),
// registered dump read port (B) and a sequential clear engine. Optional parity: REGFILE_PARITY_EN.
module reg_file_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              dump_en,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              dump_valid,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_rej,
    output logic              parity_err
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_act;
    logic              wr_acc;
    logic [DATA_W-1:0] dump_data_p0;

    assign clr_act = (state == CLEAR);
    // Writes only land while the clear engine is idle.
    assign wr_acc  = wr_en && !clr_act;

    // Stage p0: port A, zero latency, bypassed by an accepted write to the same entry
    always_comb begin
        rd_data_a = mem[rd_addr_a];
        if (wr_acc && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    // Port B source follows what the entry will hold after this edge.
    always_comb begin
        dump_data_p0 = mem[rd_addr_b];
        if (clr_act && (clr_ptr == rd_addr_b)) begin
            dump_data_p0 = '0;
        end
        if (wr_acc && (wr_addr == rd_addr_b)) begin
            dump_data_p0 = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '{default: '0};
        end else if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end else if (clr_act) begin
            mem[clr_ptr] <= '0;
        end
    end

    // Clear engine: one entry per cycle, busy for exactly DEPTH cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
            wr_rej   <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            wr_rej   <= wr_en && clr_act;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state    <= IDLE;
                        clr_ptr  <= '0;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clr_ptr <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: registered dump output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_b  <= '0;
            dump_valid <= 1'b0;
        end else begin
            rd_data_b  <= dump_en ? dump_data_p0 : '0;
            dump_valid <= dump_en;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par_mem [DEPTH];
    logic dump_par_p0;

    always_comb begin
        dump_par_p0 = par_mem[rd_addr_b];
        if (clr_act && (clr_ptr == rd_addr_b)) begin
            dump_par_p0 = 1'b0;
        end
        if (wr_acc && (wr_addr == rd_addr_b)) begin
            dump_par_p0 = ^wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_mem <= '{default: 1'b0};
        end else if (wr_acc) begin
            par_mem[wr_addr] <= ^wr_data;
        end else if (clr_act) begin
            par_mem[clr_ptr] <= 1'b0;
        end
    end

    // Stage p1: parity recheck, aligned with dump_valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= dump_en && ((^dump_data_p0) != dump_par_p0);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
